// File: rtl/prbs_gen_axis_if.sv
// Word stream bundle between the PRBS generator and its consumer.
// master drives tdata/tvalid, slave drives tready.
interface prbs_gen_axis_if #(
  parameter int OUT_W = 32
);
  logic [OUT_W-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/prbs_gen_axis.sv
// Parametrised Fibonacci LFSR PRBS generator streaming OUT_W-bit words with start/stop and count limit.
// Optional macro PRBS_ERR_INJECT_EN adds i_err_inject, which flips bit 0 of one emitted word.
module prbs_gen_axis #(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = 32'h80200003,
  parameter int                OUT_W        = 32,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [LFSR_W-1:0] i_prbs_seed,
  input  logic [31:0]       i_num_words,
`ifdef PRBS_ERR_INJECT_EN
  input  logic              i_err_inject,
`endif
  prbs_gen_axis_if.master   m_axis,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_word_cnt
);
  // state | meaning
  // IDLE  | waiting for i_start; LFSR state and word count retained
  // RUN   | presenting words until i_stop or the count limit is reached
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, seed_ld;
  logic [OUT_W-1:0]  tdata_q, word_nxt, tdata_d;
  logic              tvalid_q, done_q;
  logic [31:0]       cnt_q, limit_q;
  logic              step_fb, xfer, inj_bit;
  logic              load_seed, word_load, last_word, cnt_inc, drop_valid;

  assign seed_ld = (i_prbs_seed == '0) ? DEFAULT_SEED : i_prbs_seed;

  // OUT_W LFSR steps unrolled; the first generated bit lands in the MSB
  always_comb begin
    lfsr_nxt = lfsr_q;
    word_nxt = '0;
    step_fb  = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      step_fb               = ^(lfsr_nxt & TAPS);
      word_nxt[OUT_W-1-i]   = step_fb;
      lfsr_nxt              = {lfsr_nxt[LFSR_W-2:0], step_fb};
    end
    tdata_d    = word_nxt;
    tdata_d[0] = word_nxt[0] ^ inj_bit;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (i_stop || last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // stop takes priority over a transfer in the same cycle
  always_comb begin
    xfer       = tvalid_q & m_axis.tready;
    load_seed  = 1'b0;
    word_load  = 1'b0;
    last_word  = 1'b0;
    cnt_inc    = 1'b0;
    drop_valid = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      S_IDLE: load_seed = i_start;
      S_RUN: begin
        o_busy = 1'b1;
        if (i_stop) begin
          drop_valid = 1'b1;
        end else begin
          cnt_inc    = xfer;
          last_word  = xfer && (limit_q != '0) && ((cnt_q + 32'd1) == limit_q);
          drop_valid = last_word;
          word_load  = !last_word && (!tvalid_q || xfer);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      lfsr_q   <= DEFAULT_SEED;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
      limit_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_word;
      if (load_seed) begin
        lfsr_q  <= seed_ld;
        cnt_q   <= '0;
        limit_q <= i_num_words;
      end else if (word_load) begin
        lfsr_q <= lfsr_nxt;
      end
      if (cnt_inc) cnt_q <= cnt_q + 32'd1;
      if (drop_valid) begin
        tvalid_q <= 1'b0;
      end else if (word_load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= tdata_d;
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic err_pend_q;

  // further pulses while pending merge into the one outstanding error
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)      err_pend_q <= 1'b0;
    else if (err_pend_q) err_pend_q <= ~word_load;
    else                 err_pend_q <= i_err_inject;
  end

  assign inj_bit = err_pend_q;
`else
  assign inj_bit = 1'b0;
`endif

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign o_done        = done_q;
  assign o_word_cnt    = cnt_q;
endmodule
